arbitro_barramento: RTL

Upstream bus arbiter for the 3-processor snooping coherence system. It buffers commands from each processor in a small per-processor FIFO and picks one processor at a time, round-robin. It drives the 12-bit processor command and the 3-bit processor-select code into the snooping bus top. It holds each grant stable for one bus transaction, then forces one idle cycle before the next grant.

---
 rtl/arbitro_barramento_if.sv | 34 +++
 rtl/arbitro_barramento.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/arbitro_barramento_if.sv
// ---------------------------------------------------------------------------
// arbitro_barramento_if
// Bundles the processor request side and the granted-command side of the
// upstream bus arbiter.
//   req_valid          per-processor command valid         (master -> slave)
//   req_cmd            packed commands, proc i at [i*CMD_W +: CMD_W]
//   req_ready          per-processor FIFO can accept       (slave -> master)
//   fim_transacao      early end of the current transaction (master -> slave)
//   comandoProcessador granted command, registered         (slave -> master)
//   selecaoProcessador granted processor code, 0 = idle    (slave -> master)
//   ocupado            1 while a grant is active           (slave -> master)
// ---------------------------------------------------------------------------
interface arbitro_barramento_if #(
   parameter int N_PROC = 3,
   parameter int CMD_W  = 12
);
   logic [N_PROC-1:0]       req_valid;
   logic [N_PROC*CMD_W-1:0] req_cmd;
   logic [N_PROC-1:0]       req_ready;
   logic                    fim_transacao;
   logic [CMD_W-1:0]        comandoProcessador;
   logic [2:0]              selecaoProcessador;
   logic                    ocupado;

   modport master (
      output req_valid, req_cmd, fim_transacao,
      input  req_ready, comandoProcessador, selecaoProcessador, ocupado
   );

   modport slave (
      input  req_valid, req_cmd, fim_transacao,
      output req_ready, comandoProcessador, selecaoProcessador, ocupado
   );
endinterface

// File: rtl/arbitro_barramento.sv
// ---------------------------------------------------------------------------
// arbitro_barramento
// Upstream bus arbiter for the 3-processor snooping coherence system.
// Each processor has a small command FIFO; one processor at a time is
// granted round-robin. A grant is held for one bus transaction (at most
// TRANS_PASSOS cycles, shorter on fim_transacao) and is always followed by
// one idle cycle (bus turnaround).
// Ports:
//   clock  system clock, all state on the rising edge
//   reset  synchronous, active-high; clears FIFOs, outputs and rr pointer
//   bus    arbitro_barramento_if.slave (requests in, granted command out)
// ---------------------------------------------------------------------------
module arbitro_barramento #(
   parameter int N_PROC       = 3,
   parameter int CMD_W        = 12,
   parameter int FIFO_DEPTH   = 2,
   parameter int TRANS_PASSOS = 3
) (
   input logic                  clock,
   input logic                  reset,
   arbitro_barramento_if.slave  bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (TRANS_PASSOS > 1) ? $clog2(TRANS_PASSOS) : 1;
   localparam int IDX_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

   typedef enum logic {
      OCIOSO,
      CONCEDIDO
   } estado_t;

   // ------------------------------------------------------------------
   // Per-processor command FIFOs
   // ------------------------------------------------------------------
   logic [CMD_W-1:0] fifoMem   [N_PROC][FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr     [N_PROC];
   logic [PTR_W-1:0] rdPtr     [N_PROC];
   logic [PTR_W:0]   ocupacao  [N_PROC];
   logic [N_PROC-1:0] cheio, vazio, push, pop;

   // Ready depends on full only, so a full FIFO refuses a push even when
   // the arbiter pops it in the same cycle.
   always_comb begin
      cheio         = '0;
      vazio         = '0;
      push          = '0;
      bus.req_ready = '0;
      for (int unsigned i = 0; i < N_PROC; i++) begin
         cheio[i]         = (ocupacao[i] == (PTR_W+1)'(FIFO_DEPTH));
         vazio[i]         = (ocupacao[i] == '0);
         bus.req_ready[i] = !reset && !cheio[i];
         push[i]          = bus.req_valid[i] && bus.req_ready[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_PROC; i++) begin
            wrPtr[i]    <= '0;
            rdPtr[i]    <= '0;
            ocupacao[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_PROC; i++) begin
            if (push[i]) begin
               fifoMem[i][wrPtr[i]] <= bus.req_cmd[i*CMD_W +: CMD_W];
               wrPtr[i]             <= wrPtr[i] + PTR_W'(1);
            end
            if (pop[i]) begin
               rdPtr[i] <= rdPtr[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
               2'b10:   ocupacao[i] <= ocupacao[i] + (PTR_W+1)'(1);
               2'b01:   ocupacao[i] <= ocupacao[i] - (PTR_W+1)'(1);
               default: ocupacao[i] <= ocupacao[i];
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Round-robin pick: first non-empty FIFO after ultimo, wrapping
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] ultimo, ultimoProx;
   logic [IDX_W-1:0] candidato, escolhido;
   logic             achou;

   always_comb begin
      achou     = 1'b0;
      escolhido = ultimo;
      candidato = '0;
      for (int unsigned k = 1; k <= N_PROC; k++) begin
         candidato = IDX_W'((32'(ultimo) + k) % N_PROC);
         if (!achou && !vazio[candidato]) begin
            achou     = 1'b1;
            escolhido = candidato;
         end
      end
   end

   // ------------------------------------------------------------------
   // Grant FSM
   // ------------------------------------------------------------------
   estado_t          estado, estadoProx;
   logic [CNT_W-1:0] contador, contadorProx;
   logic [CMD_W-1:0] cmdReg, cmdProx;
   logic [2:0]       selReg, selProx;
   logic             ocupReg, ocupProx;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= OCIOSO;
         contador <= '0;
         ultimo   <= IDX_W'(N_PROC - 1);
         cmdReg   <= '0;
         selReg   <= '0;
         ocupReg  <= 1'b0;
      end else begin
         estado   <= estadoProx;
         contador <= contadorProx;
         ultimo   <= ultimoProx;
         cmdReg   <= cmdProx;
         selReg   <= selProx;
         ocupReg  <= ocupProx;
      end
   end

   always_comb begin
      estadoProx   = estado;
      contadorProx = contador;
      ultimoProx   = ultimo;
      cmdProx      = cmdReg;
      selProx      = selReg;
      ocupProx     = ocupReg;
      pop          = '0;
      case (estado)
         OCIOSO: begin
            if (achou) begin
               pop[escolhido] = 1'b1;
               cmdProx        = fifoMem[escolhido][rdPtr[escolhido]];
               selProx        = 3'(escolhido) + 3'd1;
               ultimoProx     = escolhido;
               ocupProx       = 1'b1;
               contadorProx   = '0;
               estadoProx     = CONCEDIDO;
            end
         end
         CONCEDIDO: begin
            // Returning to OCIOSO guarantees the one-cycle turnaround gap.
            if (bus.fim_transacao || contador == CNT_W'(TRANS_PASSOS - 1)) begin
               cmdProx    = '0;
               selProx    = '0;
               ocupProx   = 1'b0;
               estadoProx = OCIOSO;
            end else begin
               contadorProx = contador + CNT_W'(1);
            end
         end
         default: estadoProx = OCIOSO;
      endcase
   end

   assign bus.comandoProcessador = cmdReg;
   assign bus.selecaoProcessador = selReg;
   assign bus.ocupado            = ocupReg;

endmodule
